// File: rtl/tree_hash_pkg.sv
// rtl/tree_hash_pkg.sv - shared sizing helpers for the XOR-fold tree hash
//
// Purpose: derives the fold tree geometry from the input/output widths.
//   hash_chunks(in_w, out_w) : number of out_w-wide chunks covering in_w bits
//   hash_levels(in_w, out_w) : fold levels needed to reduce those chunks to one
// Both are constant functions and are usable in parameter expressions.

package tree_hash_pkg;

  function automatic int hash_chunks(input int in_w, input int out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

  // ceil(log2(chunks)); a single chunk needs no fold level at all.
  function automatic int hash_levels(input int in_w, input int out_w);
    int n;
    int lv;
    n  = hash_chunks(in_w, out_w);
    lv = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) lv = i + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/tree_hash_fold.sv
// rtl/tree_hash_fold.sv - one registered XOR fold level of the tree hash
//
// Purpose: folds N chunks of OUT_WIDTH bits down to N/2 chunks
//   (chunk i ^= chunk i+N/2) and registers the result with its valid bit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   halt_RnnnnL         : low holds data and valid registers
//   valid_in, data_in   : previous level (N chunks)
//   valid_out, data_out : this level's register (N/2 chunks)

module tree_hash_fold
  import tree_hash_pkg::*;
#(
  parameter int N         = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt_RnnnnL,
  input  logic                         valid_in,
  input  logic [N*OUT_WIDTH-1:0]       data_in,
  output logic                         valid_out,
  output logic [(N/2)*OUT_WIDTH-1:0]   data_out
);

  localparam int HW = (N / 2) * OUT_WIDTH;

  logic [HW-1:0] fold;
  logic [HW-1:0] data_d, data_q;
  logic          valid_d, valid_q;

  // Chunk i pairs with chunk i+N/2, so the lower half XORs the upper half.
  always_comb begin
    fold    = data_in[HW-1:0] ^ data_in[N*OUT_WIDTH-1:HW];
    valid_d = valid_q;
    data_d  = data_q;
    if (halt_RnnnnL) begin
      valid_d = valid_in;
      // An empty slot carries zero data so bubbles never leak stale values.
      data_d  = valid_in ? fold : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/tree_hash_pipe.sv
// rtl/tree_hash_pipe.sv - pipelined XOR-fold hash with programmable seed and mask
//
// Purpose: hashes IN_WIDTH bits to OUT_WIDTH bits as
//   (XOR of all OUT_WIDTH chunks ^ seed) & mask through a registered fold tree.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   halt_RnnnnL                : low stalls every stage
//   validIn_RnnH, in_RnnH      : input transaction
//   cfgWe_RnnH                 : load cfgSeed_RnnH / cfgMask_RnnH
//   validOut_RnnH, out_RnnH    : registered result

module tree_hash_pipe
  import tree_hash_pkg::*;
#(
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt_RnnnnL,
  input  logic                 validIn_RnnH,
  input  logic [IN_WIDTH-1:0]  in_RnnH,
  input  logic                 cfgWe_RnnH,
  input  logic [OUT_WIDTH-1:0] cfgSeed_RnnH,
  input  logic [OUT_WIDTH-1:0] cfgMask_RnnH,
  output logic                 validOut_RnnH,
  output logic [OUT_WIDTH-1:0] out_RnnH
);

  localparam int LEVELS = hash_levels(IN_WIDTH, OUT_WIDTH);
  localparam int NCH    = 1 << LEVELS;
  localparam int EXT_W  = NCH * OUT_WIDTH;

  // Seed / mask configuration registers.
  logic [OUT_WIDTH-1:0] seed_d, seed_q;
  logic [OUT_WIDTH-1:0] mask_d, mask_q;

  always_comb begin
    seed_d = seed_q;
    mask_d = mask_q;
    if (cfgWe_RnnH) begin
      seed_d = cfgSeed_RnnH;
      mask_d = cfgMask_RnnH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q <= '0;
      mask_q <= '1;
    end else begin
      seed_q <= seed_d;
      mask_q <= mask_d;
    end
  end

  // Preprocessing: masking distributes over XOR, so every chunk is masked
  // here and the seed is folded into chunk 0. Only data travels down the
  // pipe, which makes in-flight results immune to later config writes.
  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] pre_data;

  always_comb begin
    ext = EXT_W'(in_RnnH);
    for (int i = 0; i < NCH; i++) begin
      pre_data[i*OUT_WIDTH +: OUT_WIDTH] = ext[i*OUT_WIDTH +: OUT_WIDTH] & mask_q;
    end
    pre_data[OUT_WIDTH-1:0] = pre_data[OUT_WIDTH-1:0] ^ (seed_q & mask_q);
  end

  // Fold tree: level k narrows from NCH>>(k-1) chunks to NCH>>k chunks.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NIN = NCH >> (k - 1);

    logic [NIN*OUT_WIDTH-1:0]     din;
    logic                         vin;
    logic [(NIN/2)*OUT_WIDTH-1:0] dout;
    logic                         vout;

    if (k == 1) begin : g_first
      assign din = pre_data;
      assign vin = validIn_RnnH;
    end else begin : g_next
      assign din = g_lvl[k-1].dout;
      assign vin = g_lvl[k-1].vout;
    end

    tree_hash_fold #(
      .N         (NIN),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_fold (
      .clk         (clk),
      .rst         (rst),
      .halt_RnnnnL (halt_RnnnnL),
      .valid_in    (vin),
      .data_in     (din),
      .valid_out   (vout),
      .data_out    (dout)
    );
  end

  if (LEVELS == 0) begin : g_flat
    // Input fits in one chunk: a single register stage holds the result.
    logic [OUT_WIDTH-1:0] data_d, data_q;
    logic                 valid_d, valid_q;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (halt_RnnnnL) begin
        valid_d = validIn_RnnH;
        data_d  = validIn_RnnH ? pre_data : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign validOut_RnnH = valid_q;
    assign out_RnnH      = data_q;
  end else begin : g_tree
    assign validOut_RnnH = g_lvl[LEVELS].vout;
    assign out_RnnH      = g_lvl[LEVELS].dout;
  end

endmodule

// File: tb/tb_tree_hash_pipe.sv
// tb/tb_tree_hash_pipe.sv - directed and randomized checks of tree_hash_pipe

module tb_tree_hash_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt, vin, cfg_we;
  logic [39:0] din;
  logic [7:0]  cseed, cmask;
  logic        vout;
  logic [7:0]  dout;

  logic        v20, vo20;
  logic [19:0] in20;
  logic [7:0]  o20;
  logic        v6, vo6;
  logic [5:0]  in6;
  logic [7:0]  o6;
  logic        cfg_off;
  logic [7:0]  zero8;

  tree_hash_pipe #(.IN_WIDTH(40), .OUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .halt_RnnnnL(halt), .validIn_RnnH(vin), .in_RnnH(din),
    .cfgWe_RnnH(cfg_we), .cfgSeed_RnnH(cseed), .cfgMask_RnnH(cmask),
    .validOut_RnnH(vout), .out_RnnH(dout)
  );

  tree_hash_pipe #(.IN_WIDTH(20), .OUT_WIDTH(8)) dut20 (
    .clk(clk), .rst(rst), .halt_RnnnnL(halt), .validIn_RnnH(v20), .in_RnnH(in20),
    .cfgWe_RnnH(cfg_off), .cfgSeed_RnnH(zero8), .cfgMask_RnnH(zero8),
    .validOut_RnnH(vo20), .out_RnnH(o20)
  );

  tree_hash_pipe #(.IN_WIDTH(6), .OUT_WIDTH(8)) dut6 (
    .clk(clk), .rst(rst), .halt_RnnnnL(halt), .validIn_RnnH(v6), .in_RnnH(in6),
    .cfgWe_RnnH(cfg_off), .cfgSeed_RnnH(zero8), .cfgMask_RnnH(zero8),
    .validOut_RnnH(vo6), .out_RnnH(o6)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [7:0] fold40(input logic [39:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 5; i++) r = r ^ x[8*i +: 8];
    return r;
  endfunction

  // Accept x now (cfg_we may be set by the caller for the same cycle) and
  // expect it exactly 3 edges later, then a bubble.
  task automatic hash_one(input logic [39:0] x, input logic [7:0] exp, input string tag);
    vin = 1'b1;
    din = x;
    cyc();
    vin    = 1'b0;
    cfg_we = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check_vec($sformatf("%s_valid_e%0d", tag, c), 64'(vout), 64'(c == 3));
      if (c == 3) check_vec($sformatf("%s_data", tag), 64'(dout), 64'(exp));
      if (c < 4) cyc();
    end
  endtask

  task automatic cfg_write(input logic [7:0] s, input logic [7:0] m);
    cfg_we = 1'b1;
    cseed  = s;
    cmask  = m;
    cyc();
    cfg_we = 1'b0;
  endtask

  // Back-to-back stream with a two-cycle halt while results are in the pipe.
  bit          tv [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  logic [39:0] tin[9] = '{40'h00000000FF, 40'hFF00000000, 40'h0000000000,
                          40'h1111111111, 40'h1111111111, 40'h1111111111,
                          40'h0, 40'h0, 40'h0};
  bit          th [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
  bit          ev [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  logic [7:0]  eo [9] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h00};

  logic [7:0] q_exp[$];
  int         q_ts[$];
  int         ucnt;
  logic [7:0] mseed, mmask;

  task automatic rnd_observe(input bit unhalted);
    logic [7:0] e;
    int         ts;
    if (unhalted) begin
      ucnt++;
      if (vout) begin
        if (q_exp.size() == 0) begin
          check_vec("rnd_spurious", 64'(1), 64'(0));
        end else begin
          e  = q_exp.pop_front();
          ts = q_ts.pop_front();
          check_vec("rnd_data", 64'(dout), 64'(e));
          check_vec("rnd_latency", 64'(ucnt - ts + 1), 64'(3));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b1; vin = 1'b0; cfg_we = 1'b0; din = '0;
    cseed = '0; cmask = '0; v20 = 1'b0; in20 = '0; v6 = 1'b0; in6 = '0;
    cfg_off = 1'b0; zero8 = 8'h00;
    cyc(); cyc();
    rst = 1'b0;
    check_vec("reset_valid", 64'(vout), 64'(0));
    check_vec("reset_data", 64'(dout), 64'(0));
    check_vec("reset_valid20", 64'(vo20), 64'(0));
    check_vec("reset_valid6", 64'(vo6), 64'(0));

    hash_one(40'h0102040810, 8'h1F, "basic");

    cfg_write(8'hA5, 8'hFF);
    hash_one(40'h0102040810, 8'hBA, "seed");
    cfg_write(8'hA5, 8'h0F);
    hash_one(40'h0102040810, 8'h0A, "mask");
    cfg_we = 1'b1; cseed = 8'h00; cmask = 8'hFF;
    hash_one(40'h0102040810, 8'h0A, "samecyc_old");
    hash_one(40'h0102040810, 8'h1F, "samecyc_new");

    for (int t = 0; t < 9; t++) begin
      vin  = tv[t];
      din  = tin[t];
      halt = th[t];
      cyc();
      check_vec($sformatf("halt_valid_e%0d", t), 64'(vout), 64'(ev[t]));
      check_vec($sformatf("halt_data_e%0d", t), 64'(dout), 64'(eo[t]));
    end
    vin = 1'b0; halt = 1'b1;

    cfg_write(8'hA5, 8'h0F);
    vin = 1'b1; din = 40'h0102040810;
    cyc(); cyc();
    vin = 1'b0; rst = 1'b1; cfg_we = 1'b1; cseed = 8'h55; cmask = 8'h33;
    cyc();
    rst = 1'b0; cfg_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_vec($sformatf("rstmid_valid_%0d", c), 64'(vout), 64'(0));
      cyc();
    end
    hash_one(40'h0102040810, 8'h1F, "rstmid_cfg");

    v20 = 1'b1; in20 = 20'hF1234; v6 = 1'b1; in6 = 6'h2A;
    cyc();
    v20 = 1'b0; v6 = 1'b0;
    check_vec("w6_valid", 64'(vo6), 64'(1));
    check_vec("w6_data", 64'(o6), 64'(8'h2A));
    check_vec("w20_valid_e1", 64'(vo20), 64'(0));
    cyc();
    check_vec("w20_valid_e2", 64'(vo20), 64'(1));
    check_vec("w20_data", 64'(o20), 64'(8'h29));
    check_vec("w6_bubble", 64'(vo6), 64'(0));
    cyc();
    check_vec("w20_bubble", 64'(vo20), 64'(0));

    ucnt  = 0;
    mseed = 8'h00;
    mmask = 8'hFF;
    for (int t = 0; t < 300; t++) begin
      vin    = 1'($urandom_range(0, 1));
      din    = {8'($urandom), 32'($urandom)};
      halt   = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cseed  = 8'($urandom);
      cmask  = 8'($urandom);
      if (vin && halt) begin
        q_exp.push_back((fold40(din) ^ mseed) & mmask);
        q_ts.push_back(ucnt + 1);
      end
      if (cfg_we) begin
        mseed = cseed;
        mmask = cmask;
      end
      cyc();
      rnd_observe(halt);
    end
    vin = 1'b0; halt = 1'b1; cfg_we = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cyc();
      rnd_observe(1'b1);
    end
    check_vec("rnd_drain", 64'(q_exp.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/tree_hash_pipe.md
# tree_hash_pipe

Parametrised, pipelined XOR-fold hash for the rasterizer sample-jitter path. Generalises the fixed 40-to-8 combinational hash to arbitrary input and output widths. Adds a registered fold tree with a valid/halt handshake and a runtime-programmable seed and mask. It sits between the sample iterator and the jitter/sample-test stage and stalls with the rest of the raster pipeline.

## Interface
Parameters:
- `IN_WIDTH`, 40, width of the hash input; must be ≥ 1.
- `OUT_WIDTH`, 8, width of the hash output; must be ≥ 1.

Derived constants:
- `CHUNKS` = ceil(`IN_WIDTH`/`OUT_WIDTH`).
- `LEVELS` = ceil(log2(`CHUNKS`)).
- `STAGES` = max(1, `LEVELS`).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `halt_RnnnnL` in 1: low stalls the entire pipeline.
- `validIn_RnnH` in 1: input transaction present.
- `in_RnnH` in `IN_WIDTH`: value to hash.
- `cfgWe_RnnH` in 1: load seed and mask.
- `cfgSeed_RnnH` in `OUT_WIDTH`: seed value to load.
- `cfgMask_RnnH` in `OUT_WIDTH`: mask value to load.
- `validOut_RnnH` out 1: `out_RnnH` holds a result.
- `out_RnnH` out `OUT_WIDTH`: hashed and masked result.

## Operation
- **Chunking.**
  - `in_RnnH` is zero-extended to 2^`LEVELS` × `OUT_WIDTH` bits.
  - The extended value is split into chunks c[0..2^`LEVELS`−1]; c[0] is the LSBs.
- **Accept.** A transaction is accepted when `validIn_RnnH`=1 and `halt_RnnnnL`=1.
- **Preprocessing at accept.**
  - Each chunk becomes c[i] & mask, using the mask register value before any same-cycle write.
  - c[0] is additionally XORed with (seed & mask).
  - Masking distributes over XOR, so no mask or seed travels down the pipe.
- **Fold level k** (k=1..`LEVELS`): chunk i ← chunk i XOR chunk i+half, where half is the current chunk count divided by 2. Each level is followed by a register.
- **LEVELS=0** (`IN_WIDTH` ≤ `OUT_WIDTH`): a single register holds the preprocessed c[0].
- **Result.**
  - `out_RnnH` = (XOR of all chunks ^ seed) & mask.
  - For 40:8 this is the XOR of all five input bytes. This intentionally differs from the previous generation, whose output reduced to byte0 ^ byte4.
- **Valid bits.** A valid bit travels with every stage. A stage with valid=0 forces its data register to 0.
- **Config.**
  - `cfgWe_RnnH`=1 loads the seed and mask registers at the edge.
  - The load is independent of halt.
  - The new values apply to transactions accepted on later cycles only.
  - Transactions already in flight are unaffected.
- **Halt.**
  - While `halt_RnnnnL`=0, every stage register (data and valid) holds.
  - Inputs are ignored; upstream must hold them.
  - Outputs stay stable.

## Timing
- **Latency.** `STAGES` cycles from the accept edge to `validOut_RnnH`=1, excluding halted cycles. For 40:8 this is 3 cycles.
- **Throughput.** One transaction per unhalted cycle; no bubbles are inserted.
- **Reset values.**
  - All valid bits 0.
  - All data registers 0.
  - `out_RnnH`=0 and `validOut_RnnH`=0.
  - seed=0, mask=all ones.
- **Reset priority.**
  - `rst` overrides halt and cfg writes.
  - Reset mid-stream drops all in-flight transactions. No result from them ever appears.
- **Release.** The first accept is possible in the cycle after `rst` deasserts.
- **Same-cycle config and accept.** When `cfgWe_RnnH`, accept and an unhalted cycle coincide, the accepted transaction uses the old config.
- **Output timing.** `out_RnnH` and `validOut_RnnH` are driven directly from registers; there is no combinational input-to-output path.

## Structure
- **Package `tree_hash_pkg`.**
  - Function `hash_levels(in_w, out_w)` returns `LEVELS`.
  - Function `hash_chunks(in_w, out_w)` returns `CHUNKS`.
  - Both are usable in parameter expressions.
- **Sub-module `tree_hash_fold`.**
  - Parameters: chunk count N (a power of two ≥ 2) and `OUT_WIDTH`.
  - Behaviour: one registered fold level, N chunks to N/2 chunks, with a valid bit and halt hold.
  - Top level: instantiates `tree_hash_fold` `LEVELS` times in a generate loop.
  - The preprocessing logic and the `LEVELS`=0 register live in the top level.

## Test plan
All vectors use the default 40:8 configuration unless stated.

- **Basic hash.** After reset, accept 0x0102040810 with no halt → 3 cycles later `validOut_RnnH`=1, `out_RnnH`=0x1F; the next cycle `validOut_RnnH`=0.
- **Seed and mask.**
  - Write seed 0xA5, mask 0xFF, then accept 0x0102040810 → 0xBA.
  - Then write mask 0x0F and accept the same input → 0x0A.
  - A cfg write in the same cycle as the accept → result still uses the old config.
- **Back-to-back with halt.**
  - Accept 4 consecutive inputs: 0x00000000FF, 0xFF00000000, 0x0000000000, 0x1111111111.
  - Hold `halt_RnnnnL`=0 for 2 cycles mid-stream.
  - Expected: outputs 0xFF, 0xFF, 0x00, 0x11 in order, with outputs frozen during the halt and no duplicates or drops.
- **Reset mid-stream.** Assert `rst` with 2 transactions in flight → `validOut_RnnH` stays 0 until a new accept. Seed reads back as 0 and mask as 0xFF, confirmed by hashing 0x0102040810 → 0x1F.
- **Alternate widths.**
  - `IN_WIDTH`=20, `OUT_WIDTH`=8: input 0xF1234 → 0x34^0x12^0x0F = 0x29, latency 2.
  - `IN_WIDTH`=6, `OUT_WIDTH`=8: input 0x2A → 0x2A, latency 1.
- **Random regression.** Random inputs, halts and cfg writes compared against a reference-model XOR fold; the output stream must match exactly.
